issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue stage driving the pipelined functional units: X (ALU), MEM and Y (4-stage multiplier).
- Accepts one decoded instruction per cycle, checks per-register hazards and writeback-port conflicts, then dispatches registered operands, destination and unit select.
- On a hazard it stalls decode and sends a bubble downstream.

Parameters:
- LAT_X, 1, register stages in unit X (functionalunit code 1)
- LAT_MEM, 3, register stages in unit MEM (code 2)
- LAT_Y, 4, register stages in unit Y (code 3)
- LAT_MAX, 4, largest of the three latencies; sizes the counters and the writeback vector

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- id_is_valid  in  1  decode presents an instruction
- id_is_functionalunit  in  2  0=nop, 1=X, 2=MEM, 3=Y
- id_is_rs  in  5  source register A index
- id_is_rt  in  5  source register B index
- id_is_regdest  in  5  destination register index
- id_is_writereg  in  1  instruction writes regdest
- rf_is_rsvalue  in  32  register-file value for rs (write-before-read)
- rf_is_rtvalue  in  32  register-file value for rt
- is_id_stall  out  1  combinational; decode holds its instruction
- is_fu_functionalunit  out  2  registered unit select (0 = bubble)
- is_fu_rega  out  32  registered operand A
- is_fu_regb  out  32  registered operand B
- is_fu_regdest  out  5  registered destination
- is_fu_writereg  out  1  registered write enable

Behaviour:
- Reset (async, active-low):
  - all is_fu_* outputs = 0
  - all 32 pending counters = 0
  - writeback vector wbv[LAT_MAX+1:1] = 0
  - effective immediately, including mid-operation; in-flight reservations are discarded
- Pending counter per register: width clog2(LAT_MAX+3).
  - Dispatch with writereg=1 and regdest!=0 loads count[regdest] = L+2 (L = latency of the selected unit).
  - Every other nonzero counter decrements by 1 per clock.
  - Register 0 is never pending.
- RAW/WAW hazard: valid && fu!=0 && any of the following is true:
  - count[rs]!=0
  - count[rt]!=0
  - (writereg && count[regdest]!=0)
- The counter runs to zero even when Y suppresses the write on overflow; no writeback feedback is used.
- Writeback vector: bit k set means a result reaches writeback k edges from now.
  - Each edge: wbv_next[k] = wbv[k+1].
  - A dispatch to a unit of latency L additionally sets wbv_next[L+1 - 1 + 1] = wbv_next[L+1]; the result appears L+1 edges after the dispatch edge.
  - Port conflict when wbv[L+2] is set, i.e. it would equal L+1 after the shift.
  - Only units with writereg=1 reserve slots.
- is_id_stall = valid && fu!=0 && (hazard || port conflict). Combinational from current state and decode inputs.
- Dispatch edge, valid && !stall && fu!=0:
  - is_fu_functionalunit = fu
  - is_fu_rega = rsvalue, is_fu_regb = rtvalue
  - is_fu_regdest = regdest, is_fu_writereg = writereg
- Bubble edge (stall, !valid, or fu==0): all is_fu_* outputs = 0. A nop (fu=0) never stalls and consumes nothing.
- Same-cycle dispatch and decrement on the same register: the load wins.
- Issue-to-writeback latency: 1 issue register + L unit stages.
- The counter value L+2 covers register-file write one edge after writeback.
- Throughput: one instruction per cycle when there are no hazards.

Test Plan:
- Reset mid-run with count[5]=3 and wbv nonzero -> all is_fu_* = 0; the next independent instruction dispatches without stall.
- Y mul r3<-r1*r2, then X add r4<-r3+r1 on the next cycle -> is_id_stall=1 for exactly 6 cycles; the add dispatches on the 7th cycle with rega = the new r3.
- Y to r6, then an independent X to r7 issued 3 cycles later -> port conflict; stall for 1 cycle, then dispatch.
- Stream of independent X ops r8..r15, rs=rt=r0 -> one dispatch per cycle, is_id_stall never set.
- Y to r0, then an op reading r0 -> no hazard, no stall, r0 not pending.
- Nop (fu=0, valid=1) while a Y result is pending -> no stall; bubble output; counter keeps decrementing.

Source files
------------

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue stage with per-register pending counters and writeback-port reservation
module issue_scoreboard #(
  parameter int LAT_X   = 1,
  parameter int LAT_MEM = 3,
  parameter int LAT_Y   = 4,
  parameter int LAT_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [1:0]  id_is_functionalunit,
  input  logic [4:0]  id_is_rs,
  input  logic [4:0]  id_is_rt,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic [31:0] rf_is_rsvalue,
  input  logic [31:0] rf_is_rtvalue,
  output logic        is_id_stall,
  output logic [1:0]  is_fu_functionalunit,
  output logic [31:0] is_fu_rega,
  output logic [31:0] is_fu_regb,
  output logic [4:0]  is_fu_regdest,
  output logic        is_fu_writereg
);

  // Counter must hold LAT_MAX+2, the largest reservation length.
  localparam int CW  = $clog2(LAT_MAX + 3);
  localparam int WBW = LAT_MAX + 1;

  // Pending counters: nonzero means the register's new value is not yet in the file.
  logic [CW-1:0] count_q [32];
  logic [CW-1:0] count_d [32];

  // Writeback slot map: bit k set means a result reaches writeback k edges from now.
  logic [WBW:1]  wbv_q;
  logic [WBW:1]  wbv_d;
  logic [WBW:1]  wbv_shift;

  // Registered dispatch bundle towards the functional units.
  logic [1:0]    fu_q, fu_d;
  logic [31:0]   rega_q, rega_d;
  logic [31:0]   regb_q, regb_d;
  logic [4:0]    regdest_q, regdest_d;
  logic          writereg_q, writereg_d;

  // Decode-side qualifiers.
  int            lat;
  logic          active;
  logic          raw_waw;
  logic          slot_busy;
  logic          port_conflict;
  logic          stall;
  logic          dispatch;
  logic          reserve;

  function automatic int unit_latency(input logic [1:0] fu);
    case (fu)
      2'd1:    return LAT_X;
      2'd2:    return LAT_MEM;
      2'd3:    return LAT_Y;
      default: return 0;
    endcase
  endfunction

  // Hazard and writeback-port checks against the current scoreboard state.
  always_comb begin
    lat      = unit_latency(id_is_functionalunit);
    active   = id_is_valid && (id_is_functionalunit != 2'd0);
    raw_waw  = (count_q[id_is_rs] != '0) ||
               (count_q[id_is_rt] != '0) ||
               (id_is_writereg && (count_q[id_is_regdest] != '0));
    // The candidate lands L+1 edges after dispatch; compare against the map
    // as it will look after this edge's shift.
    wbv_shift = wbv_q >> 1;
    slot_busy = 1'b0;
    for (int k = 1; k <= WBW; k++) begin
      if (k == lat + 1) begin
        slot_busy = wbv_shift[k];
      end
    end
    // Only writing instructions occupy the writeback port.
    port_conflict = id_is_writereg && slot_busy;
    stall         = active && (raw_waw || port_conflict);
    dispatch      = active && !stall;
    reserve       = dispatch && id_is_writereg;
  end

  // Counter next state: a fresh reservation overrides the running decrement.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      count_d[r] = count_q[r];
      if (r != 0) begin
        if (reserve && (id_is_regdest == 5'(r))) begin
          count_d[r] = CW'(lat + 2);
        end else if (count_q[r] != '0) begin
          count_d[r] = count_q[r] - CW'(1);
        end
      end
    end
  end

  // Slot map advances one position per edge; a dispatch books its landing slot.
  always_comb begin
    wbv_d = wbv_shift;
    for (int k = 1; k <= WBW; k++) begin
      if (reserve && (k == lat + 1)) begin
        wbv_d[k] = 1'b1;
      end
    end
  end

  // Dispatch bundle or bubble for the next edge.
  always_comb begin
    fu_d       = 2'd0;
    rega_d     = 32'd0;
    regb_d     = 32'd0;
    regdest_d  = 5'd0;
    writereg_d = 1'b0;
    if (dispatch) begin
      fu_d       = id_is_functionalunit;
      rega_d     = rf_is_rsvalue;
      regb_d     = rf_is_rtvalue;
      regdest_d  = id_is_regdest;
      writereg_d = id_is_writereg;
    end
  end

  // State update; reset drops every in-flight reservation immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        count_q[r] <= '0;
      end
      wbv_q      <= '0;
      fu_q       <= 2'd0;
      rega_q     <= 32'd0;
      regb_q     <= 32'd0;
      regdest_q  <= 5'd0;
      writereg_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wbv_q      <= wbv_d;
      fu_q       <= fu_d;
      rega_q     <= rega_d;
      regb_q     <= regb_d;
      regdest_q  <= regdest_d;
      writereg_q <= writereg_d;
    end
  end

  assign is_id_stall          = stall;
  assign is_fu_functionalunit = fu_q;
  assign is_fu_rega           = rega_q;
  assign is_fu_regb           = regb_q;
  assign is_fu_regdest        = regdest_q;
  assign is_fu_writereg       = writereg_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - self-checking bench for issue_scoreboard against a timestamp model
module tb_issue_scoreboard;

  localparam int LX = 1;
  localparam int LM = 3;
  localparam int LY = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_is_valid;
  logic [1:0]  id_is_functionalunit;
  logic [4:0]  id_is_rs;
  logic [4:0]  id_is_rt;
  logic [4:0]  id_is_regdest;
  logic        id_is_writereg;
  logic [31:0] rf_is_rsvalue;
  logic [31:0] rf_is_rtvalue;
  logic        is_id_stall;
  logic [1:0]  is_fu_functionalunit;
  logic [31:0] is_fu_rega;
  logic [31:0] is_fu_regb;
  logic [4:0]  is_fu_regdest;
  logic        is_fu_writereg;

  issue_scoreboard #(.LAT_X(LX), .LAT_MEM(LM), .LAT_Y(LY), .LAT_MAX(4)) dut (
    .clock(clock),
    .reset(reset),
    .id_is_valid(id_is_valid),
    .id_is_functionalunit(id_is_functionalunit),
    .id_is_rs(id_is_rs),
    .id_is_rt(id_is_rt),
    .id_is_regdest(id_is_regdest),
    .id_is_writereg(id_is_writereg),
    .rf_is_rsvalue(rf_is_rsvalue),
    .rf_is_rtvalue(rf_is_rtvalue),
    .is_id_stall(is_id_stall),
    .is_fu_functionalunit(is_fu_functionalunit),
    .is_fu_rega(is_fu_rega),
    .is_fu_regb(is_fu_regb),
    .is_fu_regdest(is_fu_regdest),
    .is_fu_writereg(is_fu_writereg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: absolute edge numbers instead of counters.
  // busy_until[r]: last edge at which r still blocks readers/writers.
  // land[e]: a result is booked to reach writeback at edge e.
  int          t;
  int          busy_until [32];
  bit          land [int];
  logic [1:0]  e_fu;
  logic [31:0] e_a, e_b;
  logic [4:0]  e_rd;
  logic        e_wr;

  function automatic int lat_of(input logic [1:0] fu);
    return (fu == 2'd1) ? LX : (fu == 2'd2) ? LM : LY;
  endfunction

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && (t <= busy_until[r]);
  endfunction

  function automatic bit model_stall();
    bit haz, conf;
    if (!id_is_valid || id_is_functionalunit == 2'd0) return 1'b0;
    haz  = pend(id_is_rs) || pend(id_is_rt) || (id_is_writereg && pend(id_is_regdest));
    conf = id_is_writereg && land.exists(t + lat_of(id_is_functionalunit) + 1);
    return haz || conf;
  endfunction

  task automatic model_reset();
    t = 0;
    for (int r = 0; r < 32; r++) busy_until[r] = -1;
    land.delete();
    e_fu = '0; e_a = '0; e_b = '0; e_rd = '0; e_wr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_fu"},   32'(is_fu_functionalunit), 32'(e_fu));
    chk({tag, "_rega"}, is_fu_rega, e_a);
    chk({tag, "_regb"}, is_fu_regb, e_b);
    chk({tag, "_rd"},   32'(is_fu_regdest), 32'(e_rd));
    chk({tag, "_wr"},   32'(is_fu_writereg), 32'(e_wr));
  endtask

  // One clock: inputs already driven after a negedge.
  task automatic cycle(output bit dut_stall);
    bit exp_stall, disp;
    int L;
    #1;
    exp_stall = model_stall();
    dut_stall = is_id_stall;
    chk("stall", 32'(is_id_stall), 32'(exp_stall));
    disp = id_is_valid && (id_is_functionalunit != 2'd0) && !exp_stall;
    if (disp) begin
      L = lat_of(id_is_functionalunit);
      e_fu = id_is_functionalunit; e_a = rf_is_rsvalue; e_b = rf_is_rtvalue;
      e_rd = id_is_regdest; e_wr = id_is_writereg;
      if (id_is_writereg) begin
        land[t + L + 1] = 1'b1;
        if (id_is_regdest != 5'd0) busy_until[id_is_regdest] = t + L + 2;
      end
    end else begin
      e_fu = '0; e_a = '0; e_b = '0; e_rd = '0; e_wr = 1'b0;
    end
    t++;
    @(posedge clock);
    #1;
    check_outputs("out");
    @(negedge clock);
  endtask

  task automatic drive(input bit v, input logic [1:0] fu, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit wr, input logic [31:0] a, input logic [31:0] b);
    id_is_valid = v; id_is_functionalunit = fu; id_is_rs = rs; id_is_rt = rt;
    id_is_regdest = rd; id_is_writereg = wr; rf_is_rsvalue = a; rf_is_rtvalue = b;
  endtask

  // Present an instruction and hold it until it leaves; returns stall cycles seen.
  task automatic issue(input logic [1:0] fu, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] b, output int nstall);
    bit s;
    nstall = 0;
    drive(1'b1, fu, rs, rt, rd, wr, a, b);
    for (int i = 0; i < 20; i++) begin
      cycle(s);
      if (!s) begin
        drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        return;
      end
      nstall++;
    end
    chk("issue_timeout", 32'd1, 32'd0);
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    bit s;
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) cycle(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit s;
    bit held;
    reset = 1'b1;
    drive(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    model_reset();
    #2 reset = 1'b0;
    #1 check_outputs("reset0");
    @(negedge clock);
    reset = 1'b1;

    // Independent X stream r8..r15 with r0 sources.
    for (int r = 8; r <= 15; r++) begin
      issue(2'd1, 5'd0, 5'd0, 5'(r), 1'b1, 32'h1000 + 32'(r), 32'h2000 + 32'(r), n);
      chk("stream_nstall", 32'(n), 32'd0);
    end
    idle(6);

    // RAW on a multiplier result.
    issue(2'd3, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, n);
    issue(2'd1, 5'd3, 5'd1, 5'd4, 1'b1, 32'hCAFE_0003, 32'h11, n);
    chk("raw_nstall", 32'(n), 32'd6);
    chk("raw_rega", is_fu_rega, 32'hCAFE_0003);
    idle(8);

    // Writeback port collision between Y and a later X.
    issue(2'd3, 5'd0, 5'd0, 5'd6, 1'b1, 32'h6, 32'h6, n);
    idle(2);
    issue(2'd1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h7, 32'h7, n);
    chk("port_nstall", 32'(n), 32'd1);
    idle(8);

    // r0 is never pending.
    issue(2'd3, 5'd1, 5'd2, 5'd0, 1'b1, 32'h1, 32'h2, n);
    issue(2'd1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h9, 32'h9, n);
    chk("r0_nstall", 32'(n), 32'd0);
    idle(8);

    // A nop during a pending Y result costs nothing and time keeps running.
    issue(2'd3, 5'd1, 5'd2, 5'd5, 1'b1, 32'h5, 32'h5, n);
    drive(1'b1, 2'd0, 5'd5, 5'd5, 5'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle(s);
    chk("nop_stall", 32'(s), 32'd0);
    issue(2'd1, 5'd5, 5'd0, 5'd10, 1'b1, 32'h55, 32'h0, n);
    chk("nop_after_nstall", 32'(n), 32'd5);
    idle(8);

    // Asynchronous reset mid-run with a live reservation.
    issue(2'd3, 5'd0, 5'd0, 5'd5, 1'b1, 32'h5, 32'h5, n);
    idle(2);
    issue(2'd2, 5'd0, 5'd0, 5'd9, 1'b1, 32'hABCD, 32'h1234, n);
    chk("pre_reset_fu", 32'(is_fu_functionalunit), 32'd2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clock);
    reset = 1'b1;
    issue(2'd1, 5'd5, 5'd5, 5'd5, 1'b1, 32'h77, 32'h88, n);
    chk("post_reset_nstall", 32'(n), 32'd0);
    idle(6);

    // Randomized traffic; decode holds a stalled instruction.
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        drive(($urandom_range(0, 99) < 85), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), $urandom, $urandom);
      end else begin
        rf_is_rsvalue = $urandom;
        rf_is_rtvalue = $urandom;
      end
      cycle(s);
      held = s;
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
